// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the Execute-stage multiply/divide unit.
//   md_op_e    : RV32M funct3 encodings
//   md_state_e : controller states, also exported on the debug state port
//   XLEN, DIV0_QUOT, INT_MIN, CNT_W, CNT_INIT : datapath constants
//   mulSelect / divSelect : sign fix-up and result-half selection helpers
package md_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_INIT = 5'd31;
  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h80000000;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Product is built from magnitudes; restore the sign, then pick the half.
  function automatic logic [XLEN-1:0] mulSelect(input md_op_e op,
                                                input logic [2*XLEN-1:0] mag,
                                                input logic neg);
    logic [2*XLEN-1:0] prod;
    prod = neg ? -mag : mag;
    return (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Quotient sign is sa^sb, remainder follows the dividend.
  function automatic logic [XLEN-1:0] divSelect(input md_op_e op,
                                                input logic [XLEN-1:0] quot,
                                                input logic [XLEN-1:0] rem,
                                                input logic negQuot,
                                                input logic negRem);
    if (op == REM || op == REMU) return negRem ? -rem : rem;
    return negQuot ? -quot : quot;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one combinational iteration of the multiply/divide datapath.
//   isDiv  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo : current 64-bit accumulator halves
//            multiply: hi = partial product, lo = remaining multiplier bits
//            divide:   hi = partial remainder, lo = dividend bits / quotient bits
//   opnd   : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hiNext, loNext : accumulator after this step
module md_iter_step
  import md_pkg::*;
(
  input  logic            isDiv,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hiNext,
  output logic [XLEN-1:0] loNext
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    // Partial remainder stays below the divisor, so bit XLEN of diff is a
    // clean borrow flag.
    diff    = shifted - {1'b0, opnd};
    hiNext  = '0;
    loNext  = '0;
    if (isDiv) begin
      if (!diff[XLEN]) begin
        hiNext = diff[XLEN-1:0];
        loNext = {lo[XLEN-2:0], 1'b1};
      end else begin
        hiNext = shifted[XLEN-1:0];
        loNext = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Add then shift the 65-bit {carry, hi, lo} right by one.
      hiNext = sum[XLEN:1];
      loNext = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_e.sv
// mul_div_e: iterative RV32M multiply/divide unit in the Execute stage.
// Optional feature: define MD_FAST_MUL_EN for single-cycle multiplies
// (divides stay iterative).
// Ports:
//   clk, reset (async, active-low)
//   StartE, OpE, SrcAE, SrcBE, FlushE : instruction from the D->E register/forwarding
//   StallMD   : combinational stall request to the hazard unit
//   DoneE     : result valid this cycle
//   MDResultE : registered result, holds until the next completion
//   DbgStateE : current controller state for observation
// Handshake: an operation is accepted in IDLE when StartE=1 and FlushE=0;
// StallMD stays high until the DONE cycle, in which DoneE=1 qualifies
// MDResultE. StartE in the DONE cycle belongs to the same instruction and
// is ignored.
module mul_div_e
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            DoneE,
  output logic [XLEN-1:0] MDResultE,
  output md_state_e       DbgStateE
);

  md_state_e        stateQ, stateD;
  logic [CNT_W-1:0] countQ;
  logic [XLEN-1:0]  hiQ, loQ, opndQ;
  md_op_e           opQ;
  logic             saQ, sbQ;
  logic [XLEN-1:0]  resultQ;

  md_op_e          opE;
  logic            isDivE, saE, sbE, acceptE;
  logic            div0E, ovfE, fastMulE, specialE;
  logic [XLEN-1:0] aMagE, bMagE, specialResE;
  logic [XLEN-1:0] hiStep, loStep, finalRes;

  assign opE    = md_op_e'(OpE);
  assign isDivE = OpE[2];

  // Operand signs that matter for this op; MUL low word is sign-agnostic.
  always_comb begin
    saE = 1'b0;
    sbE = 1'b0;
    unique case (opE)
      MULH, DIV, REM: begin
        saE = SrcAE[XLEN-1];
        sbE = SrcBE[XLEN-1];
      end
      MULHSU: saE = SrcAE[XLEN-1];
      default: ;
    endcase
  end

  assign aMagE = saE ? -SrcAE : SrcAE;
  assign bMagE = sbE ? -SrcBE : SrcBE;

  assign acceptE = (stateQ == IDLE) && StartE && !FlushE;
  assign div0E   = isDivE && (SrcBE == '0);
  assign ovfE    = (opE == DIV || opE == REM) && (SrcAE == INT_MIN) && (SrcBE == '1);

`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProdE;
  assign fastMulE  = !isDivE;
  assign fastProdE = {{XLEN{1'b0}}, aMagE} * {{XLEN{1'b0}}, bMagE};
`else
  assign fastMulE  = 1'b0;
`endif

  assign specialE = div0E || ovfE || fastMulE;

  always_comb begin
    specialResE = '0;
    if (div0E) begin
      specialResE = (opE == REM || opE == REMU) ? SrcAE : DIV0_QUOT;
    end else if (ovfE) begin
      specialResE = (opE == REM) ? '0 : INT_MIN;
    end
`ifdef MD_FAST_MUL_EN
    else if (fastMulE) begin
      specialResE = mulSelect(opE, fastProdE, saE ^ sbE);
    end
`endif
  end

  md_iter_step uStep (
    .isDiv  (opQ[2]),
    .hi     (hiQ),
    .lo     (loQ),
    .opnd   (opndQ),
    .hiNext (hiStep),
    .loNext (loStep)
  );

  // Result of the last step, captured on the CALC -> DONE edge.
  always_comb begin
    if (opQ[2]) finalRes = divSelect(opQ, loStep, hiStep, saQ ^ sbQ, saQ);
    else        finalRes = mulSelect(opQ, {hiStep, loStep}, saQ ^ sbQ);
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (acceptE) stateD = specialE ? DONE : CALC;
      CALC: begin
        if (FlushE)             stateD = IDLE;
        else if (countQ == '0)  stateD = DONE;
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countQ  <= '0;
      hiQ     <= '0;
      loQ     <= '0;
      opndQ   <= '0;
      opQ     <= MUL;
      saQ     <= 1'b0;
      sbQ     <= 1'b0;
      resultQ <= '0;
    end else if (acceptE) begin
      countQ <= CNT_INIT;
      opQ    <= opE;
      saQ    <= saE;
      sbQ    <= sbE;
      hiQ    <= '0;
      // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
      loQ    <= isDivE ? aMagE : bMagE;
      opndQ  <= isDivE ? bMagE : aMagE;
      if (specialE) resultQ <= specialResE;
    end else if (stateQ == CALC && !FlushE) begin
      hiQ <= hiStep;
      loQ <= loStep;
      if (countQ == '0) resultQ <= finalRes;
      else              countQ  <= countQ - 1'b1;
    end
  end

  assign StallMD   = reset && (acceptE || stateQ == CALC);
  assign DoneE     = (stateQ == DONE) && !FlushE;
  assign MDResultE = resultQ;
  assign DbgStateE = stateQ;

endmodule

// File: tb/tb_mul_div_e.sv
// tb_mul_div_e: directed self-checking bench for mul_div_e.
module tb_mul_div_e;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_e;
  logic [2:0]  op_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush_e;
  logic        stall_md;
  logic        done_e;
  logic [31:0] md_result;
  md_state_e   dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  mul_div_e dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (start_e),
    .OpE       (op_e),
    .SrcAE     (src_a),
    .SrcBE     (src_b),
    .FlushE    (flush_e),
    .StallMD   (stall_md),
    .DoneE     (done_e),
    .MDResultE (md_result),
    .DbgStateE (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one operation, holding StartE as a stalled pipeline would, until
  // the DONE cycle; then checks latency, stall length and result.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    int stalls;
    bit got_done;
    logic [31:0] exp;
    exp_q.push_back(res);
    exp = res;
    @(negedge clk);
    start_e = 1'b1;
    op_e    = op;
    src_a   = a;
    src_b   = b;
    #1;
    stalls = stall_md ? 1 : 0;
    check({tag, "_t0_done"}, 32'(done_e), 32'd0);
    got_done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(negedge clk);
      if (done_e === 1'b1) begin
        got_done = 1'b1;
        exp = exp_q.pop_front();
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_done_stall"}, 32'(stall_md), 32'd0);
        check({tag, "_result"}, md_result, exp);
      end else if (stall_md === 1'b1) begin
        stalls++;
      end
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(lat));
    if (!got_done) begin
      void'(exp_q.pop_front());
      start_e = 1'b0;
    end
    // StartE was still high at the DONE edge; it must not have been accepted.
    @(negedge clk);
    check({tag, "_after_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_hold"}, md_result, exp);
    start_e = 1'b0;
  endtask

  initial begin
    int dones;
    reset   = 1'b0;
    start_e = 1'b1;
    op_e    = 3'b000;
    src_a   = 32'd0;
    src_b   = 32'd0;
    flush_e = 1'b0;

    // reset state, with StartE high to show the stall is gated by reset
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall_md), 32'd0);
    check("rst_done", 32'(done_e), 32'd0);
    check("rst_result", md_result, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    start_e = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // multiplies
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulh_n", 3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, MUL_LAT);

    // divides
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_op("rem_nb", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);

    // special cases
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        SPC_LAT);
    run_op("div0",   3'b100, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, SPC_LAT);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT);

    // StartE together with FlushE in IDLE: nothing accepted
    @(negedge clk);
    start_e = 1'b1;
    flush_e = 1'b1;
    op_e    = 3'b100;
    src_a   = 32'd50;
    src_b   = 32'd5;
    #1;
    check("idle_flush_stall", 32'(stall_md), 32'd0);
    @(negedge clk);
    check("idle_flush_state", 32'(dbg_state), 32'(IDLE));
    start_e = 1'b0;
    flush_e = 1'b0;

    // FlushE at T10 of a DIV
    @(negedge clk);
    start_e = 1'b1;
    op_e    = 3'b100;
    src_a   = 32'd1000;
    src_b   = 32'd3;
    repeat (10) @(negedge clk);
    flush_e = 1'b1;
    start_e = 1'b0;
    #1;
    check("flush_t10_stall", 32'(stall_md), 32'd1);
    @(negedge clk);
    flush_e = 1'b0;
    check("flush_t11_state", 32'(dbg_state), 32'(IDLE));
    check("flush_t11_stall", 32'(stall_md), 32'd0);
    dones = 0;
    repeat (35) begin
      @(negedge clk);
      if (done_e === 1'b1) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    run_op("divu_af", 3'b101, 32'd9, 32'd3, 32'd3, DIV_LAT);

    // reset low at T5 of a MUL
    @(negedge clk);
    start_e = 1'b1;
    op_e    = 3'b000;
    src_a   = 32'd3;
    src_b   = 32'd5;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_stall", 32'(stall_md), 32'd0);
    check("mrst_done", 32'(done_e), 32'd0);
    check("mrst_result", md_result, 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    start_e = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op("mul_ar", 3'b000, 32'd3, 32'd5, 32'd15, MUL_LAT);
    run_op("div_ar", 3'b100, 32'd20, 32'hFFFFFFFC, 32'hFFFFFFFB, DIV_LAT);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_div_e.md
# mul_div_e

Iterative RV32M multiply/divide unit in the Execute stage, fed directly by the D→E pipeline register and operand forwarding muxes. It accepts one M-extension operation while the instruction sits in Execute and holds the pipeline with a stall request until the result is ready. The 32-bit result then joins the ALU result path into the E→M register.

## Interface
- XLEN, 32, operand/result width; only 32 is supported
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- StartE  input  1  an M-extension instruction is valid in Execute
- OpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  XLEN  forwarded rs1
- SrcBE  input  XLEN  forwarded rs2
- FlushE  input  1  Execute flush from the hazard unit
- StallMD  output  1  stall request to the hazard unit for Fetch, Decode and Execute
- DoneE  output  1  result valid this cycle
- MDResultE  output  XLEN  result, valid only when DoneE=1

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If StartE=1 and FlushE=0, latch operand magnitudes, sign flags and op, and load count=31.
  - Next state is CALC, or DONE on a special case.
- CALC:
  - Multiply uses one shift-add step per cycle into a 64-bit accumulator.
  - Divide uses one restoring-subtract step per cycle and produces quotient and remainder.
  - count decrements each cycle. The step taken at count=0 is the last one, then next state is DONE.
- DONE:
  - DoneE=1 and MDResultE is valid. Next state is always IDLE.
  - StartE is ignored in this cycle, because it is the same instruction leaving Execute.
- Sign rules:
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MUL and MULHU: both unsigned.
  - Product is negated when the two operand signs differ. MUL returns bits [31:0]; the MULH variants return [63:32].
  - Quotient is negated when sa^sb=1. Remainder takes the sign of the dividend.
- Special cases resolve in IDLE and go straight to DONE:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = SrcAE.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- StallMD = reset & ((IDLE & StartE & ~FlushE) | CALC). It is combinational so the pipeline freezes in the accept cycle.
- FlushE in CALC or DONE forces IDLE on the next edge. DoneE is not raised for the aborted operation.
- Reset values: state IDLE, count 0, accumulators 0, DoneE 0, MDResultE 0, StallMD 0.

## Timing
- Accept cycle is T0. Iterative ops: StallMD=1 in T0..T32, DoneE=1 and StallMD=0 in T33.
- Special cases: StallMD=1 in T0, DoneE=1 in T1.
- A new StartE is accepted at the earliest in T34, or T2 after a special case. There is no back-to-back accept from DONE.
- MDResultE is registered and holds its value after DONE until the next DONE.
- Reset asserted mid-operation aborts immediately. StallMD and DoneE drop asynchronously.
- FlushE together with StartE in IDLE: nothing is accepted and StallMD=0.

## Configuration
- MD_FAST_MUL_EN defined: the four multiply ops compute a 64-bit signed/unsigned product in one cycle.
  - IDLE → DONE directly, so StallMD=1 in T0 and DoneE in T1.
  - Divide ops remain iterative.
- MD_FAST_MUL_EN undefined: all ops use the iterative path with the 33-cycle stall.

## Structure
- Package md_pkg holds:
  - md_op_e enum with the funct3 encodings
  - md_state_e enum {IDLE, CALC, DONE}
  - XLEN constant
  - DIV0_QUOT = 32'hFFFFFFFF
  - INT_MIN = 32'h80000000
- One sub-module, md_iter_step: combinational single-step datapath (shift-add or restore-subtract), instantiated once and selected by an is_div flag.

## Test plan
- MUL 7 × 0xFFFFFFFD → MDResultE 0xFFFFFFEB; DoneE at T33 (T1 with MD_FAST_MUL_EN).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. All with StallMD high for exactly one cycle.
- FlushE at T10 of a DIV → IDLE at T11, StallMD=0 from T11, no DoneE. A following DIVU 9 / 3 returns 3.
- reset low at T5 of a MUL → StallMD, DoneE and MDResultE are 0 immediately. After release, a new op completes with correct latency.
